mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter W, default 32, meaning the memory data word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 32, meaning the memory address width in bits.
REQ-003 SHALL have parameter RD_LAT, default 1, legal range 1..15, meaning the memory read latency in cycles.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port rq_read, input, 2 bits: per-requester single-cycle read pulse; bit0 is requester 0, bit1 is requester 1.
REQ-007 SHALL have port rq_write, input, 2 bits: per-requester single-cycle write pulse.
REQ-008 SHALL have port rq_readaddress, input, 2*ADDR_W bits: read address, requester i in slice [ADDR_W*(i+1)-1 -: ADDR_W].
REQ-009 SHALL have port rq_writeaddress, input, 2*ADDR_W bits: write address, same slicing.
REQ-010 SHALL have port rq_writedata, input, 2*W bits: write data, requester i in slice [W*(i+1)-1 -: W].
REQ-011 SHALL have port rq_readdata, output, 2*W bits: returned read data per requester, held until that requester's next read response.
REQ-012 SHALL have port rq_readvalid, output, 2 bits: one-cycle pulse marking rq_readdata valid.
REQ-013 SHALL have port rq_writeack, output, 2 bits: one-cycle pulse marking the write committed to memory.
REQ-014 SHALL have port rq_busy, output, 2 bits: high while the requester's pending slot is occupied.
REQ-015 SHALL have port mem_read, output, 1 bit: memory read strobe.
REQ-016 SHALL have port mem_write, output, 1 bit: memory write strobe.
REQ-017 SHALL have port mem_address, output, ADDR_W bits: memory address.
REQ-018 SHALL have port mem_writedata, output, W bits: memory write data.
REQ-019 SHALL have port mem_readdata, input, W bits: memory read data, valid in the cycle exactly RD_LAT cycles after the cycle mem_read is high.
REQ-020 SHALL have port err, output, 1 bit: sticky protocol-error flag.

Function
REQ-021 SHALL keep one pending slot per requester holding valid, op type (read/write), address and write data.
REQ-022 SHALL capture a command into the slot at the clock edge that samples the pulse, provided rq_busy[i] was low in that cycle.
REQ-023 SHALL, when a pulse arrives while rq_busy[i] is high, drop the command and set err; a slot freed on the same edge does not accept the pulse.
REQ-024 SHALL, when rq_read[i] and rq_write[i] are both high in one cycle, capture the write, drop the read and set err.
REQ-025 SHALL implement states IDLE, ISSUE, WAIT, with every output registered.
REQ-026 SHALL, in IDLE with at least one slot valid, grant, load the mem_* outputs from the granted slot, and go to ISSUE; in IDLE with no slot valid, stay in IDLE.
REQ-027 SHALL grant on round-robin when both slots are valid, choosing the requester not granted last; after reset requester 0 has priority.
REQ-028 SHALL hold mem_read or mem_write high for exactly one cycle, in ISSUE.
REQ-029 SHALL, for a write in ISSUE: on the next edge, pulse rq_writeack[i], clear the slot, and return to IDLE.
REQ-030 SHALL, for a read in ISSUE: enter WAIT with a 4-bit counter, then at the edge ending the cycle ISSUE+RD_LAT, latch mem_readdata into the slice of rq_readdata, pulse rq_readvalid[i], clear the slot, and return to IDLE.
REQ-031 SHALL have the following latency from a request pulse in cycle 0 with the arbiter idle: mem strobe in cycle 2, rq_writeack in cycle 3, rq_readvalid in cycle 3+RD_LAT.
REQ-032 SHALL hold mem_address and mem_writedata stable from ISSUE until the next grant; mem_read and mem_write are low outside ISSUE.

Reset
REQ-033 SHALL, on rst (including mid-operation), in the following cycle: clear all slots, state IDLE, mem_read=mem_write=0, mem_address=0, mem_writedata=0, rq_readdata=0, rq_readvalid=0, rq_writeack=0, rq_busy=0, err=0, priority to requester 0; no response is issued for an aborted transaction.

Verification
REQ-034 SHALL pass this test (RD_LAT=1): requester 0 read pulse at address 0x40 in cycle 0, memory returns 0xA5 -> mem_read=1 with mem_address=0x40 in cycle 2, and rq_readvalid=01 with rq_readdata[W-1:0]=0xA5 in cycle 4.
REQ-035 SHALL pass this test: requester 0 and requester 1 write pulses in the same cycle -> requester 0 written first, requester 1 one grant later; rq_writeack pulses in order 01, then 10; err=0.
REQ-036 SHALL pass this test: back-to-back reads from both requesters held continuously pending -> grants alternate 0,1,0,1; no requester starved.
REQ-037 SHALL pass this test: second read pulse from requester 1 while rq_busy[1]=1 -> command dropped, err=1 until rst, first read completes normally.
REQ-038 SHALL pass this test: rst asserted in WAIT -> no rq_readvalid, all outputs at reset values next cycle, new request afterwards served with the REQ-031 latency.
REQ-039 SHALL pass this test: rq_read[0] and rq_write[0] high together -> only the write issued, rq_writeack=01, err=1.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: one pending slot per requester, round-robin
// grant, IDLE/ISSUE/WAIT sequencing toward a fixed-latency memory.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   rq_read / rq_write        per-requester command pulses (bit i = requester i)
//   rq_readaddress            per-requester read address slices
//   rq_writeaddress           per-requester write address slices
//   rq_writedata              per-requester write data slices
//   rq_readdata / rq_readvalid  returned read data (held) and its one-cycle pulse
//   rq_writeack               one-cycle pulse when a write was committed
//   rq_busy                   pending slot occupied
//   mem_read / mem_write      one-cycle memory strobes
//   mem_address / mem_writedata  memory address and write data
//   mem_readdata              read data, valid RD_LAT cycles after mem_read
//   err                       sticky protocol-error flag
module mem_arbiter #(
    parameter int W      = 32,
    parameter int ADDR_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          rq_read,
    input  logic [1:0]          rq_write,
    input  logic [2*ADDR_W-1:0] rq_readaddress,
    input  logic [2*ADDR_W-1:0] rq_writeaddress,
    input  logic [2*W-1:0]      rq_writedata,
    output logic [2*W-1:0]      rq_readdata,
    output logic [1:0]          rq_readvalid,
    output logic [1:0]          rq_writeack,
    output logic [1:0]          rq_busy,
    output logic                mem_read,
    output logic                mem_write,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [W-1:0]        mem_writedata,
    input  logic [W-1:0]        mem_readdata,
    output logic                err
);

    localparam logic [3:0] LAT_M1 = 4'(RD_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [1:0]         r_valid;
    logic [1:0]         r_wr;
    logic [ADDR_W-1:0]  r_addr [2];
    logic [W-1:0]       r_data [2];
    logic               r_last;
    logic               r_gnt;
    logic [3:0]         r_cnt;

    logic               w_gnt;
    logic               w_grant;
    logic               w_wr_done;
    logic               w_rd_done;
    logic               w_err;
    logic [1:0]         w_acc_wr;
    logic [1:0]         w_acc_rd;

    assign rq_busy = r_valid;

    always_comb begin
        // Contention goes to whoever was not granted last.
        w_gnt     = (&r_valid) ? ~r_last : r_valid[1];
        w_grant   = (r_state == S_IDLE) && (|r_valid);
        w_wr_done = (r_state == S_ISSUE) && r_wr[r_gnt];
        w_rd_done = (r_state == S_WAIT) && (r_cnt == 4'd0);
        // Capture decisions use the busy flag of this cycle only, so a slot
        // freed on the same edge still rejects the pulse.
        w_acc_wr  = rq_write & ~r_valid;
        w_acc_rd  = rq_read & ~rq_write & ~r_valid;
        w_err     = (|((rq_read | rq_write) & r_valid))
                  | (|(rq_read & rq_write));
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (|r_valid) w_next = S_ISSUE;
            S_ISSUE: w_next = r_wr[r_gnt] ? S_IDLE : S_WAIT;
            S_WAIT:  if (r_cnt == 4'd0) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_wr    <= '0;
            for (int i = 0; i < 2; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_acc_wr[i]) begin
                    r_valid[i] <= 1'b1;
                    r_wr[i]    <= 1'b1;
                    r_addr[i]  <= rq_writeaddress[ADDR_W*i +: ADDR_W];
                    r_data[i]  <= rq_writedata[W*i +: W];
                end else if (w_acc_rd[i]) begin
                    r_valid[i] <= 1'b1;
                    r_wr[i]    <= 1'b0;
                    r_addr[i]  <= rq_readaddress[ADDR_W*i +: ADDR_W];
                end else if ((w_wr_done || w_rd_done) && (r_gnt == i[0])) begin
                    r_valid[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rq_readdata   <= '0;
            rq_readvalid  <= '0;
            rq_writeack   <= '0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_address   <= '0;
            mem_writedata <= '0;
            err           <= 1'b0;
            r_last        <= 1'b1;
            r_gnt         <= 1'b0;
            r_cnt         <= '0;
        end else begin
            rq_readvalid <= '0;
            rq_writeack  <= '0;
            if (w_err) err <= 1'b1;
            if (w_grant) begin
                r_gnt         <= w_gnt;
                r_last        <= w_gnt;
                mem_address   <= r_addr[w_gnt];
                mem_writedata <= r_data[w_gnt];
                mem_read      <= ~r_wr[w_gnt];
                mem_write     <= r_wr[w_gnt];
            end
            if (r_state == S_ISSUE) begin
                mem_read  <= 1'b0;
                mem_write <= 1'b0;
                r_cnt     <= LAT_M1;
            end
            if (r_state == S_WAIT) r_cnt <= r_cnt - 4'd1;
            if (w_wr_done) rq_writeack[r_gnt] <= 1'b1;
            if (w_rd_done) begin
                rq_readvalid[r_gnt] <= 1'b1;
                if (r_gnt) rq_readdata[2*W-1 -: W] <= mem_readdata;
                else       rq_readdata[W-1:0]      <= mem_readdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed latency/arbitration/error/reset cases
// plus randomized traffic, scored by a per-requester command queue model.
module tb_mem_arbiter;

    localparam int W      = 32;
    localparam int AW     = 32;
    localparam int RD_LAT = 1;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } cmd_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    rq_read = '0;
    logic [1:0]    rq_write = '0;
    logic [2*AW-1:0] rq_readaddress = '0;
    logic [2*AW-1:0] rq_writeaddress = '0;
    logic [2*W-1:0]  rq_writedata = '0;
    logic [2*W-1:0]  rq_readdata;
    logic [1:0]    rq_readvalid;
    logic [1:0]    rq_writeack;
    logic [1:0]    rq_busy;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_address;
    logic [W-1:0]  mem_writedata;
    logic [W-1:0]  mem_readdata = '0;
    logic          err;

    mem_arbiter #(.W(W), .ADDR_W(AW), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .rq_read(rq_read), .rq_write(rq_write),
        .rq_readaddress(rq_readaddress),
        .rq_writeaddress(rq_writeaddress),
        .rq_writedata(rq_writedata),
        .rq_readdata(rq_readdata),
        .rq_readvalid(rq_readvalid),
        .rq_writeack(rq_writeack),
        .rq_busy(rq_busy),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address),
        .mem_writedata(mem_writedata),
        .mem_readdata(mem_readdata),
        .err(err)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_checks = 0;
    int          n_fail = 0;
    cmd_t        q0[$];
    cmd_t        q1[$];
    cmd_t        iss_q[$];
    int          ord_q[$];
    logic [1:0]  out = '0;
    logic        exp_err = 1'b0;
    int          strobe_cyc = 0;
    logic [31:0] strobe_addr = '0;
    int          resp_cyc[2];
    logic        ring_v[16];
    logic [31:0] ring_a[16];

    // Memory contents: a fixed function of the address.
    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h40) return 32'hA5;
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory model: returns data for a read strobed RD_LAT cycles earlier.
    always @(posedge clk) begin
        int idx;
        #1;
        idx = (cyc + 16 - RD_LAT) % 16;
        if (ring_v[idx] === 1'b1) mem_readdata = memf(ring_a[idx]);
        else                      mem_readdata = $urandom;
    end

    task automatic resp(input int i);
        cmd_t e;
        cmd_t s;
        int   qn;
        check("resp_excl", {63'd0, rq_readvalid[i] & rq_writeack[i]}, 0);
        qn = (i == 0) ? q0.size() : q1.size();
        check("resp_expected", {63'd0, qn != 0}, 1);
        if (qn == 0) return;
        if (i == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        check("resp_kind", {63'd0, rq_writeack[i]}, {63'd0, e.wr});
        if (!e.wr)
            check("rdata", rq_readdata[i*W +: W], memf(e.addr));
        check("iss_present", {63'd0, iss_q.size() != 0}, 1);
        if (iss_q.size() != 0) begin
            s = iss_q.pop_front();
            check("iss_kind", {63'd0, s.wr}, {63'd0, e.wr});
            check("iss_addr", s.addr, e.addr);
            if (e.wr) check("iss_wdata", s.data, e.data);
        end
        ord_q.push_back(i);
        resp_cyc[i] = cyc;
        out[i] = 1'b0;
    endtask

    always @(negedge clk) begin
        cmd_t s;
        ring_v[cyc % 16] = mem_read;
        ring_a[cyc % 16] = mem_address;
        if (mem_read || mem_write) begin
            check("strobe_excl", {63'd0, mem_read & mem_write}, 0);
            s.wr   = mem_write;
            s.addr = mem_address;
            s.data = mem_writedata;
            iss_q.push_back(s);
            strobe_cyc  = cyc;
            strobe_addr = mem_address;
        end
        for (int i = 0; i < 2; i++)
            if (rq_readvalid[i] || rq_writeack[i]) resp(i);
    end

    task automatic drive(input logic [1:0] rd, input logic [1:0] wr,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1);
        logic [31:0] a[2];
        logic [31:0] d[2];
        cmd_t        c;
        a[0] = a0; a[1] = a1;
        d[0] = d0; d[1] = d1;
        for (int i = 0; i < 2; i++) begin
            if (rd[i] || wr[i]) begin
                if (rd[i] && wr[i]) exp_err = 1'b1;
                if (out[i]) begin
                    exp_err = 1'b1;
                end else begin
                    c.wr   = wr[i];
                    c.addr = wr[i] ? a[i] + 32'd4 : a[i];
                    c.data = d[i];
                    if (i == 0) q0.push_back(c);
                    else        q1.push_back(c);
                    out[i] = 1'b1;
                end
            end
        end
        rq_readaddress  = {a1, a0};
        rq_writeaddress = {a1 + 32'd4, a0 + 32'd4};
        rq_writedata    = {d1, d0};
        rq_read  = rd;
        rq_write = wr;
        tick();
        rq_read  = '0;
        rq_write = '0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (out != 2'b00 && n < budget) begin
            tick();
            n++;
        end
        check("idle_timeout", {62'd0, out}, 0);
        repeat (4) tick();
        check("iss_drained", iss_q.size(), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        q0.delete();
        q1.delete();
        iss_q.delete();
        ord_q.delete();
        out = '0;
        exp_err = 1'b0;
        @(negedge clk);
        check("rst_rdata", rq_readdata, 0);
        check("rst_mem", {mem_address, mem_writedata}, 0);
        check("rst_ctl", {54'd0, rq_readvalid, rq_writeack, rq_busy,
                          mem_read, mem_write, err}, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic lat_run(input logic wr, input logic [31:0] addr);
        int t0;
        t0 = cyc;
        if (wr) drive(2'b00, 2'b01, addr, 0, 32'hCAFE0001, 0);
        else    drive(2'b01, 2'b00, addr, 0, 0, 0);
        wait_idle(50);
        check("lat_strobe", strobe_cyc - t0, 2);
        check("lat_resp", resp_cyc[0] - t0, wr ? 3 : 3 + RD_LAT);
        check("lat_addr", strobe_addr, wr ? addr + 32'd4 : addr);
        check("lat_err", {63'd0, err}, {63'd0, exp_err});
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [1:0] rd;
        logic [1:0] wr;
        int         sent[2];
        for (int i = 0; i < 16; i++) begin
            ring_v[i] = 1'b0;
            ring_a[i] = '0;
        end
        resp_cyc[0] = 0;
        resp_cyc[1] = 0;
        repeat (3) tick();
        do_reset();

        // Read latency and data, then hold of returned data.
        lat_run(1'b0, 32'h40);
        check("rdata_hold", rq_readdata[31:0], 32'hA5);
        // Write latency.
        lat_run(1'b1, 32'h80);

        // Simultaneous writes: requester 0 first after reset.
        do_reset();
        drive(2'b00, 2'b11, 32'h600, 32'h700, 32'hAAAA0000, 32'hBBBB0000);
        wait_idle(50);
        check("ww_n", ord_q.size(), 2);
        if (ord_q.size() == 2) begin
            check("ww_first", ord_q[0], 0);
            check("ww_second", ord_q[1], 1);
        end
        check("ww_err", {63'd0, err}, {63'd0, exp_err});

        // Both requesters kept pending: grants alternate.
        do_reset();
        sent[0] = 0;
        sent[1] = 0;
        for (int k = 0; k < 200 && ord_q.size() < 8; k++) begin
            rd = '0;
            for (int i = 0; i < 2; i++)
                if (!out[i] && sent[i] < 4) begin
                    rd[i] = 1'b1;
                    sent[i]++;
                end
            drive(rd, 2'b00, 32'h800 + 32'(k), 32'h900 + 32'(k), 0, 0);
        end
        wait_idle(50);
        check("rr_n", ord_q.size(), 8);
        for (int k = 0; k < ord_q.size(); k++)
            check("rr_order", ord_q[k], k % 2);
        check("rr_err", {63'd0, err}, {63'd0, exp_err});

        // Pulse while busy: dropped, sticky error.
        do_reset();
        drive(2'b10, 2'b00, 0, 32'h100, 0, 0);
        drive(2'b10, 2'b00, 0, 32'h200, 0, 0);
        wait_idle(50);
        check("busy_err", {63'd0, err}, {63'd0, exp_err});
        check("busy_n", ord_q.size(), 1);
        repeat (5) tick();
        check("busy_err_sticky", {63'd0, err}, 1);

        // Read and write together: write wins.
        do_reset();
        drive(2'b01, 2'b01, 32'h300, 0, 32'h12345678, 0);
        wait_idle(50);
        check("rw_err", {63'd0, err}, {63'd0, exp_err});
        check("rw_n", ord_q.size(), 1);

        // Reset during WAIT aborts silently; new request then served.
        do_reset();
        drive(2'b01, 2'b00, 32'h500, 0, 0, 0);
        tick();
        tick();
        check("busy_in_wait", {62'd0, rq_busy}, 2'b01);
        do_reset();
        repeat (4) tick();
        lat_run(1'b0, 32'h44);

        // Random traffic with flow control on outstanding commands.
        do_reset();
        for (int k = 0; k < 400; k++) begin
            rd = '0;
            wr = '0;
            for (int i = 0; i < 2; i++)
                if (!out[i] && $urandom_range(0, 2) == 0) begin
                    if ($urandom_range(0, 1) == 1) wr[i] = 1'b1;
                    else                           rd[i] = 1'b1;
                end
            drive(rd, wr, $urandom, $urandom, $urandom, $urandom);
        end
        wait_idle(100);
        check("rand_err", {63'd0, err}, {63'd0, exp_err});
        check("rand_q_empty", q0.size() + q1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
